// File: rtl/pe_ctrl_pkg.sv
// pe_ctrl_pkg
//   Shared types and constants for the PE sequencer.
//   state_t  : sequencer FSM states
//   pe_tag_t : per-issue tag carried alongside the PE pipeline
//   PE_LAT, ISSUE_TO_PSUM : pipeline depths seen from the issue cycle
package pe_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Tag coordinate fields are sized for the largest supported geometry.
  // Each instance keeps only the low NW/HW bits.
  localparam int TAG_W         = 12;
  localparam int PE_LAT        = 3;
  localparam int ISSUE_TO_PSUM = 4;

  typedef struct packed {
    logic             valid;
    logic             first;
    logic             last;
    logic [TAG_W-1:0] n;
    logic [TAG_W-1:0] r;
    logic [TAG_W-1:0] c;
  } pe_tag_t;

endpackage

// File: rtl/pe_tag_pipe.sv
// pe_tag_pipe
//   ISSUE_TO_PSUM-deep delay line of issue tags.
//   clk, rst  : clock, async active-high reset (clears every stage)
//   tag_in    : tag for the current issue slot (valid=0 for a bubble)
//   tag_s3    : tag at stage PE_LAT (drives PE run)
//   tag_s4    : tag at stage ISSUE_TO_PSUM (aligned with pe_psum)
//   any_valid : some stage still holds a live slot
module pe_tag_pipe
  import pe_ctrl_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  pe_tag_t tag_in,
  output pe_tag_t tag_s3,
  output pe_tag_t tag_s4,
  output logic    any_valid
);

  pe_tag_t stage [ISSUE_TO_PSUM];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ISSUE_TO_PSUM; i++) stage[i] <= '0;
    end else begin
      stage[0] <= tag_in;
      for (int i = 1; i < ISSUE_TO_PSUM; i++) stage[i] <= stage[i-1];
    end
  end

  assign tag_s3 = stage[PE_LAT-1];
  assign tag_s4 = stage[ISSUE_TO_PSUM-1];

  always_comb begin
    any_valid = 1'b0;
    for (int i = 0; i < ISSUE_TO_PSUM; i++) any_valid = any_valid | stage[i].valid;
  end

endmodule

// File: rtl/pe_seq_ctrl.sv
// pe_seq_ctrl
//   Sequencer and chunk accumulator for one dot-product PE.
//   Walks (n, r, c, k) with k innermost, issues window-buffer reads, raises
//   pe_run when the slot reaches the PE, and sums NCHUNK partial sums into
//   one tagged pixel result.
//   clk, rst              : clock, async active-high reset
//   start                 : begin a pass (honoured only in IDLE)
//   hold                  : freeze issue while in RUN
//   pe_psum               : PE partial sum, valid 4 cycles after issue
//   rd_en, i_addr, w_addr : window-buffer read strobe and addresses
//   pe_run                : PE run, 3 cycles after issue
//   acc_valid, acc_data   : one-cycle pixel result strobe and sum
//   acc_n, acc_r, acc_c   : result tags
//   busy, done            : pass in progress / end-of-pass pulse
//
//   state | meaning
//   IDLE  | counters at 0, waiting for start
//   RUN   | issuing one chunk per cycle unless hold
//   DRAIN | issues finished, pipeline emptying
//   DONE  | one-cycle done pulse
module pe_seq_ctrl
  import pe_ctrl_pkg::*;
#(
  parameter  int HOUT       = 56,
  parameter  int N          = 256,
  parameter  int NCHUNK     = 80,
  parameter  int PSUM_WIDTH = 16,
  parameter  int ACC_WIDTH  = 24,
  localparam int IADDR_W    = $clog2(HOUT*HOUT*NCHUNK),
  localparam int WADDR_W    = $clog2(N*NCHUNK),
  localparam int NW         = $clog2(N),
  localparam int HW         = $clog2(HOUT)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         hold,
  input  logic signed [PSUM_WIDTH-1:0] pe_psum,
  output logic                         rd_en,
  output logic [IADDR_W-1:0]           i_addr,
  output logic [WADDR_W-1:0]           w_addr,
  output logic                         pe_run,
  output logic                         acc_valid,
  output logic signed [ACC_WIDTH-1:0]  acc_data,
  output logic [NW-1:0]                acc_n,
  output logic [HW-1:0]                acc_r,
  output logic [HW-1:0]                acc_c,
  output logic                         busy,
  output logic                         done
);

  // A single-chunk configuration still needs a 1-bit k counter.
  localparam int KW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  state_t state, state_nxt;

  logic [NW-1:0] n_q;
  logic [HW-1:0] r_q, c_q;
  logic [KW-1:0] k_q;
  logic          k_last, c_last, r_last, n_last, pass_last;

  pe_tag_t tag_in, tag_s3, tag_s4;
  logic    pipe_busy;

  logic signed [ACC_WIDTH-1:0] acc, psum_ext, acc_sum;

  assign k_last    = (k_q == KW'(NCHUNK-1));
  assign c_last    = (c_q == HW'(HOUT-1));
  assign r_last    = (r_q == HW'(HOUT-1));
  assign n_last    = (n_q == NW'(N-1));
  assign pass_last = n_last & r_last & c_last & k_last;

  // FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    rd_en     = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (!hold) begin
          rd_en = 1'b1;
          if (pass_last) state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        busy = 1'b1;
        // Last live slot leaves stage 4 the cycle before the pipe reads
        // empty, so its acc_valid is on the bus when this fires.
        if (!pipe_busy) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Loop counters, k innermost
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      n_q <= '0;
      r_q <= '0;
      c_q <= '0;
      k_q <= '0;
    end else if (state == IDLE) begin
      n_q <= '0;
      r_q <= '0;
      c_q <= '0;
      k_q <= '0;
    end else if (rd_en) begin
      if (!k_last) begin
        k_q <= k_q + KW'(1);
      end else begin
        k_q <= '0;
        if (!c_last) begin
          c_q <= c_q + HW'(1);
        end else begin
          c_q <= '0;
          if (!r_last) begin
            r_q <= r_q + HW'(1);
          end else begin
            r_q <= '0;
            n_q <= n_last ? '0 : n_q + NW'(1);
          end
        end
      end
    end
  end

  assign i_addr = IADDR_W'((int'(r_q) * HOUT + int'(c_q)) * NCHUNK + int'(k_q));
  assign w_addr = WADDR_W'(int'(n_q) * NCHUNK + int'(k_q));

  // Tag pipeline
  always_comb begin
    tag_in       = '0;
    tag_in.valid = rd_en;
    tag_in.first = (k_q == '0);
    tag_in.last  = k_last;
    tag_in.n     = TAG_W'(n_q);
    tag_in.r     = TAG_W'(r_q);
    tag_in.c     = TAG_W'(c_q);
  end

  pe_tag_pipe u_tag_pipe (
    .clk       (clk),
    .rst       (rst),
    .tag_in    (tag_in),
    .tag_s3    (tag_s3),
    .tag_s4    (tag_s4),
    .any_valid (pipe_busy)
  );

  assign pe_run = tag_s3.valid;

  // Accumulator; bubbles leave acc untouched
  assign psum_ext = {{(ACC_WIDTH-PSUM_WIDTH){pe_psum[PSUM_WIDTH-1]}}, pe_psum};
  assign acc_sum  = tag_s4.first ? psum_ext : acc + psum_ext;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc       <= '0;
      acc_valid <= 1'b0;
      acc_data  <= '0;
      acc_n     <= '0;
      acc_r     <= '0;
      acc_c     <= '0;
    end else begin
      acc_valid <= 1'b0;
      if (tag_s4.valid) begin
        acc <= acc_sum;
        if (tag_s4.last) begin
          acc_valid <= 1'b1;
          acc_data  <= acc_sum;
          acc_n     <= tag_s4.n[NW-1:0];
          acc_r     <= tag_s4.r[HW-1:0];
          acc_c     <= tag_s4.c[HW-1:0];
        end
      end
    end
  end

endmodule
